// File: rtl/tse_ctrl_pkg.sv
// Shared definitions for the TSE MAC control sequencer: register map,
// command_config bit positions, FSM states and PHY status decoding.
package tse_ctrl_pkg;

    localparam int AV_ADDR_W = 8;
    localparam int AV_DATA_W = 32;

    localparam logic [AV_ADDR_W-1:0] REG_CMD_CONFIG = 8'h02;
    localparam logic [AV_ADDR_W-1:0] REG_MAC_0      = 8'h03;
    localparam logic [AV_ADDR_W-1:0] REG_MAC_1      = 8'h04;
    localparam logic [AV_ADDR_W-1:0] REG_FRM_LENGTH = 8'h05;
    localparam logic [AV_ADDR_W-1:0] REG_MDIO_ADDR0 = 8'h0F;
    localparam logic [AV_ADDR_W-1:0] REG_MDIO0_BASE = 8'h80;
    localparam logic [AV_ADDR_W-1:0] PHY_REG_SSR    = 8'h11;

    localparam int CMD_TX_ENA    = 0;
    localparam int CMD_RX_ENA    = 1;
    localparam int CMD_ETH_SPEED = 3;
    localparam int CMD_SW_RESET  = 13;
    localparam int CMD_ENA_10    = 25;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_RST_WR,
        ST_RST_POLL,
        ST_CFG,
        ST_ENABLE,
        ST_POLL_WAIT,
        ST_PHY_RD,
        ST_SPEED_WR,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic link;
        logic set_1000;
        logic set_10;
    } link_sts_t;

    // PHY specific status: link on bit 10, speed on 15:14. A down link
    // reports the 100 Mb/s default so the MAC speed inputs stay quiet.
    function automatic link_sts_t decode_phy_sts(input logic [15:0] sts);
        link_sts_t r;
        r      = '0;
        r.link = sts[10];
        if (sts[10]) begin
            case (sts[15:14])
                2'd2:    r.set_1000 = 1'b1;
                2'd0:    r.set_10   = 1'b1;
                default: r.set_1000 = 1'b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [AV_DATA_W-1:0] cmd_enable_word(input logic s1000,
                                                             input logic s10);
        logic [AV_DATA_W-1:0] w;
        w                = '0;
        w[CMD_TX_ENA]    = 1'b1;
        w[CMD_RX_ENA]    = 1'b1;
        w[CMD_ETH_SPEED] = s1000;
        w[CMD_ENA_10]    = s10;
        return w;
    endfunction

endpackage

// File: rtl/tse_mac_init_seq_if.sv
// Avalon-MM control-port bundle between the sequencer (master) and the MAC.
interface tse_mac_init_seq_if;
    import tse_ctrl_pkg::*;

    logic [AV_ADDR_W-1:0] av_address;
    logic                 av_read;
    logic                 av_write;
    logic [AV_DATA_W-1:0] av_writedata;
    logic [AV_DATA_W-1:0] av_readdata;
    logic                 av_waitrequest;

    modport master (
        output av_address, av_read, av_write, av_writedata,
        input  av_readdata, av_waitrequest
    );

    modport slave (
        input  av_address, av_read, av_write, av_writedata,
        output av_readdata, av_waitrequest
    );

endinterface

// File: rtl/tse_avmm_xfer.sv
// Single-transfer Avalon-MM master: drives one read/write while req is held.
// Latency: strobe in the request cycle; done pulses the cycle waitrequest is low.
// Backpressure: holds strobe/address/data while waitrequest is high; one idle cycle after each transfer.
module tse_avmm_xfer
    import tse_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 wr,
    input  logic [AV_ADDR_W-1:0] addr,
    input  logic [AV_DATA_W-1:0] wdata,
    output logic                 done,
    output logic [AV_DATA_W-1:0] rdata,
    tse_mac_init_seq_if.master   av
);

    logic gap_q;
    logic gap_d;
    logic active;

    // Strobes are combinational from the requester's state so an async
    // reset of that state drops them immediately.
    always_comb begin
        active          = req & ~gap_q;
        av.av_read      = active & ~wr;
        av.av_write     = active & wr;
        av.av_address   = active ? addr : '0;
        av.av_writedata = (active & wr) ? wdata : '0;
        done            = active & ~av.av_waitrequest;
        rdata           = av.av_readdata;
        gap_d           = done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q <= 1'b0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/tse_mac_init_seq.sv
// Post-reset TSE MAC bring-up (soft reset, address, frame length, enable) and PHY link/speed tracking.
// Latency: 16-clock settle, then one Avalon transfer per step; speed outputs update the cycle after the PHY read.
// Backpressure: every transfer stalls on av_waitrequest; the poll interval restarts after each update.
module tse_mac_init_seq
    import tse_ctrl_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR    = 48'h00_1C_23_17_4A_CB,
    parameter int          MAX_FRAME   = 1518,
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter int          POLL_CYCLES = 1_000_000,
    parameter int          RST_TIMEOUT = 1024
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    tse_mac_init_seq_if.master av,
    output logic               set_1000,
    output logic               set_10,
    output logic               link_up,
    output logic               init_done,
    output logic               init_err
);

    localparam int POLL_W = $clog2(POLL_CYCLES + 1);
    localparam int RD_W   = $clog2(RST_TIMEOUT + 1);

    localparam logic [AV_DATA_W-1:0] MAC0_WORD =
        {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]};
    localparam logic [AV_DATA_W-1:0] MAC1_WORD =
        {16'h0000, MAC_ADDR[7:0], MAC_ADDR[15:8]};

    state_e             state_q,    state_d;
    logic [3:0]         init_cnt_q, init_cnt_d;
    logic [RD_W-1:0]    rd_cnt_q,   rd_cnt_d;
    logic [1:0]         cfg_idx_q,  cfg_idx_d;
    logic [POLL_W-1:0]  poll_cnt_q, poll_cnt_d;
    link_sts_t          sts_q,      sts_d;
    logic               init_done_q, init_done_d;
    logic               init_err_q,  init_err_d;

    logic                 xfer_req;
    logic                 xfer_wr;
    logic [AV_ADDR_W-1:0] xfer_addr;
    logic [AV_DATA_W-1:0] xfer_wdata;
    logic                 xfer_done;
    logic [AV_DATA_W-1:0] xfer_rdata;
    link_sts_t            phy_sts;
    logic                 unused_rdata_hi;

    assign unused_rdata_hi = ^xfer_rdata[31:16];

    tse_avmm_xfer u_xfer (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .req   (xfer_req),
        .wr    (xfer_wr),
        .addr  (xfer_addr),
        .wdata (xfer_wdata),
        .done  (xfer_done),
        .rdata (xfer_rdata),
        .av    (av)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        cfg_idx_d   = cfg_idx_q;
        poll_cnt_d  = poll_cnt_q;
        sts_d       = sts_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        xfer_req    = 1'b0;
        xfer_wr     = 1'b0;
        xfer_addr   = '0;
        xfer_wdata  = '0;
        phy_sts     = decode_phy_sts(xfer_rdata[15:0]);

        case (state_q)
            ST_INIT_WAIT: begin
                if (init_cnt_q == 4'd15) begin
                    state_d = ST_RST_WR;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end

            ST_RST_WR: begin
                xfer_req   = 1'b1;
                xfer_wr    = 1'b1;
                xfer_addr  = REG_CMD_CONFIG;
                xfer_wdata = AV_DATA_W'(1) << CMD_SW_RESET;
                if (xfer_done) begin
                    state_d  = ST_RST_POLL;
                    rd_cnt_d = '0;
                end
            end

            ST_RST_POLL: begin
                xfer_req  = 1'b1;
                xfer_addr = REG_CMD_CONFIG;
                if (xfer_done) begin
                    if (!xfer_rdata[CMD_SW_RESET]) begin
                        state_d   = ST_CFG;
                        cfg_idx_d = 2'd0;
                    end else if (rd_cnt_q == RD_W'(RST_TIMEOUT - 1)) begin
                        state_d    = ST_ERR;
                        init_err_d = 1'b1;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RD_W'(1);
                    end
                end
            end

            ST_CFG: begin
                xfer_req = 1'b1;
                xfer_wr  = 1'b1;
                case (cfg_idx_q)
                    2'd0: begin
                        xfer_addr  = REG_MAC_0;
                        xfer_wdata = MAC0_WORD;
                    end
                    2'd1: begin
                        xfer_addr  = REG_MAC_1;
                        xfer_wdata = MAC1_WORD;
                    end
                    2'd2: begin
                        xfer_addr  = REG_FRM_LENGTH;
                        xfer_wdata = AV_DATA_W'(MAX_FRAME);
                    end
                    default: begin
                        xfer_addr  = REG_MDIO_ADDR0;
                        xfer_wdata = {27'd0, PHY_ADDR};
                    end
                endcase
                if (xfer_done) begin
                    if (cfg_idx_q == 2'd3) begin
                        state_d = ST_ENABLE;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 2'd1;
                    end
                end
            end

            ST_ENABLE, ST_SPEED_WR: begin
                xfer_req   = 1'b1;
                xfer_wr    = 1'b1;
                xfer_addr  = REG_CMD_CONFIG;
                xfer_wdata = cmd_enable_word(sts_q.set_1000, sts_q.set_10);
                if (xfer_done) begin
                    init_done_d = 1'b1;
                    state_d     = ST_POLL_WAIT;
                    poll_cnt_d  = POLL_W'(POLL_CYCLES);
                end
            end

            ST_POLL_WAIT: begin
                // Reloaded to POLL_CYCLES on entry; leaving at 1 gives POLL_CYCLES clocks here.
                if (poll_cnt_q <= POLL_W'(1)) begin
                    state_d = ST_PHY_RD;
                end else begin
                    poll_cnt_d = poll_cnt_q - POLL_W'(1);
                end
            end

            ST_PHY_RD: begin
                xfer_req  = 1'b1;
                xfer_addr = REG_MDIO0_BASE + PHY_REG_SSR;
                if (xfer_done) begin
                    if (phy_sts == sts_q) begin
                        state_d    = ST_POLL_WAIT;
                        poll_cnt_d = POLL_W'(POLL_CYCLES);
                    end else begin
                        sts_d   = phy_sts;
                        state_d = ST_SPEED_WR;
                    end
                end
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_INIT_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_INIT_WAIT;
            init_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            cfg_idx_q   <= '0;
            poll_cnt_q  <= '0;
            sts_q       <= '0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            cfg_idx_q   <= cfg_idx_d;
            poll_cnt_q  <= poll_cnt_d;
            sts_q       <= sts_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    assign link_up   = sts_q.link;
    assign set_1000  = sts_q.set_1000;
    assign set_10    = sts_q.set_10;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;

endmodule

// File: tb/tb_tse_mac_init_seq.sv
// Directed bench for tse_mac_init_seq: slave model with 3 waitrequest cycles per access,
// write log, protocol monitors, and hand-computed expected register traffic.
module tb_tse_mac_init_seq;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    logic set_1000, set_10, link_up, init_done, init_err;

    always #5 clk_clk = ~clk_clk;

    tse_mac_init_seq_if av_if ();

    tse_mac_init_seq #(
        .MAC_ADDR    (48'h00_1C_23_17_4A_CB),
        .MAX_FRAME   (1518),
        .PHY_ADDR    (5'd0),
        .POLL_CYCLES (40),
        .RST_TIMEOUT (1024)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .av            (av_if),
        .set_1000      (set_1000),
        .set_10        (set_10),
        .link_up       (link_up),
        .init_done     (init_done),
        .init_err      (init_err)
    );

    logic [31:0] sw_hold = 32'd5;
    logic [15:0] phy_sts = 16'h0000;

    logic [2:0]  wcnt;
    logic [31:0] cmd_rd_cnt, phy_rd_cnt, wr_n;
    logic [7:0]  wr_addr [0:63];
    logic [31:0] wr_data [0:63];
    logic        prev_done;
    logic        strobe, xfer_done;
    logic [31:0] viol_both = 32'd0, viol_gap = 32'd0, viol_speed = 32'd0;

    always_comb begin
        strobe                = av_if.av_read | av_if.av_write;
        av_if.av_waitrequest  = strobe && (wcnt < 3'd3);
        xfer_done             = strobe && !av_if.av_waitrequest;
        av_if.av_readdata     = 32'h0;
        if (av_if.av_address == 8'h02)
            av_if.av_readdata = (cmd_rd_cnt < sw_hold) ? 32'h0000_2000 : 32'h0;
        else if (av_if.av_address == 8'h91)
            av_if.av_readdata = {16'h0, phy_sts};
    end

    always @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wcnt       <= 3'd0;
            cmd_rd_cnt <= 32'd0;
            phy_rd_cnt <= 32'd0;
            wr_n       <= 32'd0;
            prev_done  <= 1'b0;
        end else begin
            wcnt      <= (xfer_done || !strobe) ? 3'd0 : wcnt + 3'd1;
            prev_done <= xfer_done;
            if (xfer_done && av_if.av_write) begin
                if (wr_n < 32'd64) begin
                    wr_addr[wr_n[5:0]] <= av_if.av_address;
                    wr_data[wr_n[5:0]] <= av_if.av_writedata;
                end
                wr_n <= wr_n + 32'd1;
            end
            if (xfer_done && av_if.av_read && av_if.av_address == 8'h02)
                cmd_rd_cnt <= cmd_rd_cnt + 32'd1;
            if (xfer_done && av_if.av_read && av_if.av_address == 8'h91)
                phy_rd_cnt <= phy_rd_cnt + 32'd1;
        end
    end

    always @(posedge clk_clk) begin
        if (av_if.av_read && av_if.av_write) viol_both <= viol_both + 32'd1;
        if (prev_done && strobe && reset_reset_n) viol_gap <= viol_gap + 32'd1;
        if (set_1000 && set_10) viol_speed <= viol_speed + 32'd1;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_init_seq(input string pfx, input logic [31:0] exp_rds);
        logic [7:0]  ea [0:5];
        logic [31:0] ed [0:5];
        ea = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 8'h02};
        ed = '{32'h0000_2000, 32'h1723_1C00, 32'h0000_CB4A,
               32'h0000_05EE, 32'h0000_0000, 32'h0000_0003};
        check({pfx, "_wr_count"}, 64'(wr_n), 64'd6);
        check({pfx, "_rst_reads"}, 64'(cmd_rd_cnt), 64'(exp_rds));
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_wr%0d", pfx, i),
                  {24'h0, wr_addr[i], wr_data[i]}, {24'h0, ea[i], ed[i]});
    endtask

    task automatic wait_init_done(input string tag);
        for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk_clk);
        check(tag, 64'(init_done), 64'd1);
    endtask

    task automatic expect_speed_wr(input string tag, input logic [31:0] exp_data,
                                   input logic e_link, input logic e_1000, input logic e_10);
        logic [31:0] base;
        base = wr_n;
        for (int i = 0; i < 1000 && wr_n == base; i++) @(negedge clk_clk);
        check({tag, "_wr"}, {24'h0, wr_addr[base[5:0]], wr_data[base[5:0]]},
              {24'h0, 8'h02, exp_data});
        check({tag, "_outs"}, {61'h0, link_up, set_1000, set_10}, {61'h0, e_link, e_1000, e_10});
    endtask

    initial begin
        logic [31:0] base_w, base_r;

        // Reset state
        repeat (3) @(negedge clk_clk);
        check("reset_strobes", {62'h0, av_if.av_read, av_if.av_write}, 64'd0);
        check("reset_outs", {59'h0, set_1000, set_10, link_up, init_done, init_err}, 64'd0);
        reset_reset_n = 1'b1;

        // Bring-up with SW_RESET held for 5 reads, PHY link down
        wait_init_done("init_done_1");
        check_init_seq("boot", 32'd6);
        check("boot_outs", {61'h0, link_up, set_1000, set_10}, 64'd0);

        phy_sts = 16'h8400;
        expect_speed_wr("spd1000", 32'h0000_000B, 1'b1, 1'b1, 1'b0);
        phy_sts = 16'h0400;
        expect_speed_wr("spd10", 32'h0200_0003, 1'b1, 1'b0, 1'b1);
        phy_sts = 16'h0000;
        expect_speed_wr("linkdown", 32'h0000_0003, 1'b0, 1'b0, 1'b0);

        // Unchanged status: keep polling, no writes
        base_w = wr_n;
        base_r = phy_rd_cnt;
        repeat (300) @(negedge clk_clk);
        check("steady_no_wr", 64'(wr_n), 64'(base_w));
        check("steady_polls", 64'((phy_rd_cnt - base_r) >= 32'd3), 64'd1);

        // Async reset clears live outputs immediately
        phy_sts = 16'h8400;
        expect_speed_wr("relink", 32'h0000_000B, 1'b1, 1'b1, 1'b0);
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1 check("async_rst_outs", {61'h0, link_up, set_1000, init_done}, 64'd0);

        // Reset in the middle of a CFG write
        phy_sts = 16'h0000;
        sw_hold = 32'd0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int i = 0; i < 1000 && !(av_if.av_write && av_if.av_address == 8'h04); i++)
            @(negedge clk_clk);
        check("cfg_mac1_seen", {63'h0, av_if.av_write}, 64'd1);
        #2 reset_reset_n = 1'b0;
        #1 check("midwr_strobe_drop",
                 {23'h0, av_if.av_write, av_if.av_address, av_if.av_writedata}, 64'd0);
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        wait_init_done("init_done_2");
        check_init_seq("rerun", 32'd1);

        // SW_RESET never clears
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        sw_hold = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int i = 0; i < 8000 && !init_err; i++) @(negedge clk_clk);
        check("timeout_err", 64'(init_err), 64'd1);
        check("timeout_reads", 64'(cmd_rd_cnt), 64'd1024);
        repeat (50) @(negedge clk_clk);
        check("err_quiet_reads", 64'(cmd_rd_cnt), 64'd1024);
        check("err_quiet_wr", 64'(wr_n), 64'd1);
        check("err_state", {61'h0, av_if.av_read, init_done, init_err}, 64'd1);

        check("viol_rd_wr_both", 64'(viol_both), 64'd0);
        check("viol_no_gap", 64'(viol_gap), 64'd0);
        check("viol_speed_both", 64'(viol_speed), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
